// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a byte plus odd parity on device clock falling edges and checks the ack.
module ps2_host_tx #(
  parameter int TICK_DIV      = 250,
  parameter int INHIBIT_TICKS = 40,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       TX_START,
  input  logic [7:0] TX_DATA,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX  = (TIMEOUT_TICKS > INHIBIT_TICKS) ? TIMEOUT_TICKS : INHIBIT_TICKS;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_TICKS - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE} state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       bit_idx;
  logic [9:0]       frame;
  logic             tick;
  logic             clk_s;
  logic             data_s;
  logic             fall;
  logic             tmo_hit;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign tick    = (div_cnt == DIV_LAST);
  assign fall    = tick && clk_prev && !clk_s;
  assign tmo_hit = tick && (tmr == TMO_LAST);

  // Line synchronizers, free-running tick divider and tick-rate edge history.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
      div_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK_IN};
      data_sync <= {data_sync[0], PS2_DATA_IN};
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      if (tick) clk_prev <= clk_s;
    end
  end

  // Frame sequencer; frame holds {stop, parity, data} so index k selects bit k.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      tmr         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          PS2_CLK_OE  <= 1'b0;
          PS2_DATA_OE <= 1'b0;
          if (TX_START) begin
            frame      <= {1'b1, ~^TX_DATA, TX_DATA};
            BUSY       <= 1'b1;
            PS2_CLK_OE <= 1'b1;
            tmr        <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (tick) begin
            if (tmr == INH_LAST) begin
              tmr         <= '0;
              PS2_DATA_OE <= 1'b1;
              state       <= REQ;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state       <= IDLE;
            ERR         <= 1'b1;
            BUSY        <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
          end else if (tick) begin
            PS2_CLK_OE <= 1'b0;
            bit_idx    <= '0;
            tmr        <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (fall) begin
            PS2_DATA_OE <= ~frame[bit_idx];
            tmr         <= '0;
            if (bit_idx == 4'd9) state <= ACK;
            else bit_idx <= bit_idx + 1'b1;
          end else if (tmo_hit) begin
            state       <= IDLE;
            ERR         <= 1'b1;
            BUSY        <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
          end else if (tick) begin
            tmr <= tmr + 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            tmr <= '0;
            if (!data_s) begin
              state <= RELEASE;
            end else begin
              state       <= IDLE;
              ERR         <= 1'b1;
              BUSY        <= 1'b0;
              PS2_CLK_OE  <= 1'b0;
              PS2_DATA_OE <= 1'b0;
            end
          end else if (tmo_hit) begin
            state       <= IDLE;
            ERR         <= 1'b1;
            BUSY        <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
          end else if (tick) begin
            tmr <= tmr + 1'b1;
          end
        end
        RELEASE: begin
          if (clk_s && data_s) begin
            state <= IDLE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else if (tmo_hit) begin
            state       <= IDLE;
            ERR         <= 1'b1;
            BUSY        <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
          end else if (tick) begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          BUSY        <= 1'b0;
          PS2_CLK_OE  <= 1'b0;
          PS2_DATA_OE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: an open-drain PS/2 device model receives frames
// while a scoreboard matches every DONE/ERR pulse against the expected outcome.
module tb_ps2_host_tx;

  localparam int TICK_DIV      = 4;
  localparam int INHIBIT_TICKS = 5;
  localparam int TIMEOUT_TICKS = 30;

  typedef struct {
    bit        expect_done;
    bit        chk_frame;
    bit        chk_tmo;
    bit [10:0] frame;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TX_START = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         inh_cnt = 0;
  int         last_inhibit = 0;
  int         dev_last_fall_cyc = 0;
  logic [10:0] dev_rx = '0;
  exp_t       exp_q[$];
  exp_t       mon_e;

  // Open-drain bus: either side pulling low wins, otherwise the pull-up holds it high.
  assign ps2_clk_line  = ~(PS2_CLK_OE | dev_clk_low);
  assign ps2_data_line = ~(PS2_DATA_OE | dev_data_low);

  ps2_host_tx #(
    .TICK_DIV(TICK_DIV),
    .INHIBIT_TICKS(INHIBIT_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .TX_START(TX_START),
    .TX_DATA(TX_DATA),
    .PS2_CLK_IN(ps2_clk_line),
    .PS2_DATA_IN(ps2_data_line),
    .PS2_CLK_OE(PS2_CLK_OE),
    .PS2_DATA_OE(PS2_DATA_OE),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Length of each clock-inhibit window, measured in CLK cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (PS2_CLK_OE && !PS2_DATA_OE) begin
        inh_cnt++;
      end else begin
        if (inh_cnt > 0) last_inhibit = inh_cnt;
        inh_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every DONE/ERR pulse consumes one expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (DONE || ERR) begin
        checkOutput("done_err_exclusive", 32'(DONE & ERR), 32'd0);
        checkOutput("busy_at_end", 32'(BUSY), 32'd0);
        checkOutput("oe_at_end", 32'({PS2_CLK_OE, PS2_DATA_OE}), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_pulse: got DONE=%0b ERR=%0b expected none", DONE, ERR);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("outcome_done", 32'(DONE), 32'(mon_e.expect_done));
          checkOutput("outcome_err", 32'(ERR), 32'(!mon_e.expect_done));
          if (mon_e.chk_frame) checkOutput("frame_bits", 32'(dev_rx), 32'(mon_e.frame));
          if (mon_e.expect_done)
            checkRange("inhibit_len", last_inhibit, (INHIBIT_TICKS - 1) * TICK_DIV,
                       (INHIBIT_TICKS + 1) * TICK_DIV);
          if (mon_e.chk_tmo)
            checkRange("timeout_len", cyc - dev_last_fall_cyc, (TIMEOUT_TICKS - 1) * TICK_DIV,
                       (TIMEOUT_TICKS + 2) * TICK_DIV);
        end
      end
    end
  end

  // Device side of a host-to-device frame: waits for request-to-send, clocks out
  // up to 'falls' edges sampling data on each rising edge, then the ack edge.
  task automatic deviceFrame(input int falls, input bit ack);
    int half;
    int guard;
    logic [10:0] rx;
    half  = $urandom_range(5, 3) * TICK_DIV;
    guard = 0;
    rx    = '0;
    while (!(ps2_clk_line && !ps2_data_line) && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    checkOutput("rts_seen", 32'(guard < 1000), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      if (k > falls) return;
      repeat (half) @(negedge CLK);
      if (k == 1) rx[0] = ps2_data_line;
      dev_clk_low = 1'b1;
      dev_last_fall_cyc = cyc;
      repeat (half) @(negedge CLK);
      rx[k] = ps2_data_line;
      dev_clk_low = 1'b0;
    end
    dev_rx = rx;
    repeat (half) @(negedge CLK);
    if (ack) dev_data_low = 1'b1;
    repeat (half) @(negedge CLK);
    dev_clk_low = 1'b1;
    dev_last_fall_cyc = cyc;
    repeat (half) @(negedge CLK);
    dev_clk_low = 1'b0;
    repeat (half) @(negedge CLK);
    dev_data_low = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int falls, input bit ack,
                               input bit expect_entry, input bit spurious);
    exp_t e;
    int guard;
    e.expect_done = (falls >= 10) && ack;
    e.chk_frame   = (falls >= 10);
    e.chk_tmo     = (falls < 10);
    e.frame       = {1'b1, ($countones(data) % 2 == 0), data, 1'b0};
    if (expect_entry) exp_q.push_back(e);
    @(negedge CLK);
    TX_DATA  = data;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
    TX_DATA  = 8'($urandom);
    checkOutput("busy_after_start", 32'(BUSY), 32'd1);
    fork
      deviceFrame(falls, ack);
      if (spurious) begin
        repeat (30) @(negedge CLK);
        TX_DATA  = ~data;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
      end
    join
    if (expect_entry) begin
      guard = 0;
      while (BUSY && guard < 2000) begin
        @(negedge CLK);
        guard++;
      end
      checkOutput("busy_released", 32'(BUSY), 32'd0);
    end
  endtask

  // Device-initiated clocking while the host is idle must be ignored entirely.
  task automatic idleTraffic();
    int active;
    active = 0;
    for (int k = 0; k < 11; k++) begin
      dev_data_low = 1'($urandom);
      repeat (12) begin
        @(negedge CLK);
        if (BUSY || PS2_CLK_OE || PS2_DATA_OE) active++;
      end
      dev_clk_low = 1'b1;
      repeat (12) begin
        @(negedge CLK);
        if (BUSY || PS2_CLK_OE || PS2_DATA_OE) active++;
      end
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
    checkOutput("idle_traffic_ignored", 32'(active), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_clk_oe", 32'(PS2_CLK_OE), 32'd0);
    checkOutput("reset_data_oe", 32'(PS2_DATA_OE), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_done", 32'(DONE), 32'd0);
    checkOutput("reset_err", 32'(ERR), 32'd0);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);

    applyStimulus(8'hED, 10, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h00, 10, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'($urandom), 10, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'($urandom), 4, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'($urandom), 10, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h3C, 10, 1'b1, 1'b1, 1'b1);

    idleTraffic();
    repeat (10) @(negedge CLK);

    // Abort mid-frame with bit 5 (a zero) still being driven, then reset.
    applyStimulus(8'hC3, 6, 1'b1, 1'b0, 1'b0);
    checkOutput("data_oe_bit5", 32'(PS2_DATA_OE), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("async_reset_clk_oe", 32'(PS2_CLK_OE), 32'd0);
    checkOutput("async_reset_data_oe", 32'(PS2_DATA_OE), 32'd0);
    checkOutput("async_reset_busy", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (200) @(negedge CLK);
    applyStimulus(8'hF4, 10, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      applyStimulus(8'($urandom), 10, 1'b1, 1'b1, 1'($urandom_range(1, 0)));

    repeat (20) @(negedge CLK);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
